// File: rtl/rsa_pkg.sv
// Shared definitions for the systolic-array output drain: combine modes,
// per-row occupancy states and saturation bounds.
package rsa_pkg;

  typedef enum logic [1:0] {
    RSA_MODE_C    = 2'b00,
    RSA_MODE_ADD  = 2'b01,
    RSA_MODE_SUB  = 2'b10,
    RSA_MODE_RSUB = 2'b11
  } rsa_mode_e;

  typedef enum logic [1:0] {
    ROW_EMPTY,
    ROW_PARTIAL,
    ROW_FULL
  } row_state_e;

  // Largest signed value of a dw-bit word, zero-extended to 64 bits.
  function automatic logic [63:0] rsa_sat_max(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Smallest signed value of a dw-bit word, sign-extended to 64 bits.
  function automatic logic [63:0] rsa_sat_min(input int unsigned dw);
    return ~((64'd1 << (dw - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/rsa_row_fifo.sv
// First-word-fall-through FIFO for one array row; occupancy tracked
// separately from the wrapping read/write pointers.
module rsa_row_fifo
  import rsa_pkg::*;
#(
  parameter int unsigned RSA_DW = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [RSA_DW-1:0]        wdata,
  output logic [RSA_DW-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [RSA_DW-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  row_state_e        state;
  logic              do_push;
  logic              do_pop;

  // Occupancy state decoded from the count.
  always_comb begin
    state = ROW_PARTIAL;
    if (count == '0)
      state = ROW_EMPTY;
    else if (count == FULL_CNT)
      state = ROW_FULL;
  end

  assign full  = (state == ROW_FULL);
  assign empty = (state == ROW_EMPTY);

  // A full row still accepts a push when the same edge pops it.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Pointer and occupancy bookkeeping; flush empties the row.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rsa_drain.sv
// Output drain for the systolic PE array: registered per-row combine with
// optional saturation, then per-row deskew FIFOs popped as one aligned column.
module rsa_drain
  import rsa_pkg::*;
#(
  parameter int unsigned X      = 4,
  parameter int unsigned RSA_DW = 32,
  parameter int unsigned DEPTH  = 8,
  parameter bit          SAT    = 1'b1
) (
  input  logic                            clk,
  input  logic                            sys_rst,
  input  logic                            flush,
  input  logic [X-1:0]                    in_val,
  input  logic [X*RSA_DW-1:0]             in_data,
  input  logic [X*RSA_DW-1:0]             M_data,
  input  logic [2*X-1:0]                  row_mode,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic [X*RSA_DW-1:0]             out_data,
  output logic [X-1:0]                    ovf_flag,
  output logic [X-1:0]                    drop_flag,
  output logic [X*($clog2(DEPTH)+1)-1:0]  row_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [63:0] MAX64 = rsa_sat_max(RSA_DW);
  localparam logic [63:0] MIN64 = rsa_sat_min(RSA_DW);
  localparam logic [RSA_DW-1:0] MAX_V = MAX64[RSA_DW-1:0];
  localparam logic [RSA_DW-1:0] MIN_V = MIN64[RSA_DW-1:0];

  logic [X-1:0]      cmb_val;
  logic [RSA_DW-1:0] cmb_data [X];
  logic [RSA_DW-1:0] nxt_data [X];
  logic [X-1:0]      nxt_ovf;
  logic [RSA_DW:0]   c_x;
  logic [RSA_DW:0]   m_x;
  logic [RSA_DW:0]   r_x;
  logic [X-1:0]      full;
  logic [X-1:0]      empty;
  logic              pop;

  // Per-row combine at RSA_DW+1 bits; a sign/carry disagreement is overflow.
  always_comb begin
    nxt_ovf = '0;
    c_x     = '0;
    m_x     = '0;
    r_x     = '0;
    for (int unsigned i = 0; i < X; i++) begin
      nxt_data[i] = '0;
    end
    for (int unsigned i = 0; i < X; i++) begin
      c_x = {in_data[i*RSA_DW+RSA_DW-1], in_data[i*RSA_DW +: RSA_DW]};
      m_x = {M_data[i*RSA_DW+RSA_DW-1], M_data[i*RSA_DW +: RSA_DW]};
      case (rsa_mode_e'(row_mode[2*i +: 2]))
        RSA_MODE_ADD:  r_x = c_x + m_x;
        RSA_MODE_SUB:  r_x = c_x - m_x;
        RSA_MODE_RSUB: r_x = m_x - c_x;
        default:       r_x = c_x;
      endcase
      nxt_ovf[i] = r_x[RSA_DW] ^ r_x[RSA_DW-1];
      if (nxt_ovf[i] && SAT)
        nxt_data[i] = r_x[RSA_DW] ? MIN_V : MAX_V;
      else
        nxt_data[i] = r_x[RSA_DW-1:0];
    end
  end

  assign out_val = ~|empty;
  assign pop     = out_val & out_rdy;

  // Combine register and sticky flags; flush discards the current input.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cmb_val   <= '0;
      ovf_flag  <= '0;
      drop_flag <= '0;
      for (int unsigned i = 0; i < X; i++) cmb_data[i] <= '0;
    end else if (flush) begin
      cmb_val   <= '0;
      ovf_flag  <= '0;
      drop_flag <= '0;
      for (int unsigned i = 0; i < X; i++) cmb_data[i] <= '0;
    end else begin
      cmb_val   <= in_val;
      ovf_flag  <= ovf_flag | (in_val & nxt_ovf);
      drop_flag <= drop_flag | (cmb_val & full & ~{X{pop}});
      for (int unsigned i = 0; i < X; i++) begin
        if (in_val[i]) cmb_data[i] <= nxt_data[i];
      end
    end
  end

  for (genvar g = 0; g < X; g++) begin : g_row
    rsa_row_fifo #(
      .RSA_DW (RSA_DW),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .sys_rst (sys_rst),
      .flush   (flush),
      .push    (cmb_val[g]),
      .pop     (pop),
      .wdata   (cmb_data[g]),
      .head    (out_data[g*RSA_DW +: RSA_DW]),
      .full    (full[g]),
      .empty   (empty[g]),
      .count   (row_cnt[g*CW +: CW])
    );
  end

endmodule

// File: tb/tb_rsa_drain.sv
// Bench for rsa_drain: a saturating and a wrapping instance share stimulus;
// a queue-based model is compared every cycle, plus literal spot checks.
module tb_rsa_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  in_val;
  logic [31:0] in_data;
  logic [31:0] m_data;
  logic [7:0]  row_mode;
  logic        out_rdy;

  logic [1:0]        dv;
  logic [1:0][31:0]  dd;
  logic [1:0][3:0]   dov;
  logic [1:0][3:0]   ddr;
  logic [1:0][11:0]  dc;

  int total = 0;
  int bad   = 0;
  int xfer  = 0;

  always #5 clk = ~clk;

  rsa_drain #(.X(4), .RSA_DW(8), .DEPTH(4), .SAT(1'b1)) u_sat (
    .clk(clk), .sys_rst(rst_n), .flush(flush), .in_val(in_val),
    .in_data(in_data), .M_data(m_data), .row_mode(row_mode),
    .out_val(dv[0]), .out_rdy(out_rdy), .out_data(dd[0]),
    .ovf_flag(dov[0]), .drop_flag(ddr[0]), .row_cnt(dc[0]));

  rsa_drain #(.X(4), .RSA_DW(8), .DEPTH(4), .SAT(1'b0)) u_wrap (
    .clk(clk), .sys_rst(rst_n), .flush(flush), .in_val(in_val),
    .in_data(in_data), .M_data(m_data), .row_mode(row_mode),
    .out_val(dv[1]), .out_rdy(out_rdy), .out_data(dd[1]),
    .ovf_flag(dov[1]), .drop_flag(ddr[1]), .row_cnt(dc[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: index 0 saturating, 1 wrapping ----------------
  int             mq [2][4][$];
  int             pend_d [2][4];
  logic [3:0]     pend_v;
  logic [1:0][3:0] mov;
  logic [1:0][3:0] mdr;

  function automatic int model_comb(input int c, input int m, input int mode,
                                    input bit sat, output bit ov);
    int r;
    case (mode)
      1:       r = c + m;
      2:       r = c - m;
      3:       r = m - c;
      default: r = c;
    endcase
    ov = (r > 127) || (r < -128);
    if (!ov) return r;
    if (sat) return (r > 127) ? 127 : -128;
    return ((r & 255) > 127) ? (r & 255) - 256 : (r & 255);
  endfunction

  function automatic bit exp_val(input int s);
    for (int i = 0; i < 4; i++) if (mq[s][i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_data(input int s);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++)
      if (mq[s][i].size() > 0) v[i*8 +: 8] = 8'(mq[s][i][0]);
    return v;
  endfunction

  function automatic logic [11:0] exp_cnt(input int s);
    logic [11:0] v = '0;
    for (int i = 0; i < 4; i++) v[i*3 +: 3] = 3'(mq[s][i].size());
    return v;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) mq[s][i].delete();
    pend_v = '0;
    mov    = '0;
    mdr    = '0;
  endfunction

  // Model update: columns leave only when all rows hold data; a row takes
  // its pending result if it has room after any same-edge pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      model_clear();
    end else begin
      for (int s = 0; s < 2; s++) begin
        bit popm;
        popm = exp_val(s) && out_rdy;
        for (int i = 0; i < 4; i++) begin
          if (popm) void'(mq[s][i].pop_front());
          if (pend_v[i]) begin
            if (mq[s][i].size() < 4) mq[s][i].push_back(pend_d[s][i]);
            else mdr[s][i] = 1'b1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (in_val[i]) begin
          for (int s = 0; s < 2; s++) begin
            bit ov;
            pend_d[s][i] = model_comb(int'($signed(in_data[i*8 +: 8])),
                                      int'($signed(m_data[i*8 +: 8])),
                                      int'(row_mode[2*i +: 2]), (s == 0), ov);
            if (ov) mov[s][i] = 1'b1;
          end
        end
      end
      pend_v = in_val;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        chk(s == 0 ? "sat_out_val"  : "wrap_out_val",  32'(dv[s]),  32'(exp_val(s)));
        chk(s == 0 ? "sat_out_data" : "wrap_out_data", dd[s],       exp_data(s));
        chk(s == 0 ? "sat_row_cnt"  : "wrap_row_cnt",  32'(dc[s]),  32'(exp_cnt(s)));
        chk(s == 0 ? "sat_ovf"      : "wrap_ovf",      32'(dov[s]), 32'(mov[s]));
        chk(s == 0 ? "sat_drop"     : "wrap_drop",     32'(ddr[s]), 32'(mdr[s]));
      end
      if (dv[0] && out_rdy) xfer++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int i, input int c, input int m, input int mode);
    in_data[i*8 +: 8]  = 8'(c);
    m_data[i*8 +: 8]   = 8'(m);
    row_mode[2*i +: 2] = 2'(mode);
  endtask

  task automatic push_col(input int base);
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(base + i);
    in_val = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int xs;
    logic [31:0] cap;
    rst_n = 1'b0; flush = 1'b0; in_val = '0; in_data = '0;
    m_data = '0; row_mode = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_out_val", 32'(dv[s]), 32'd0);
      chk("reset_row_cnt", 32'(dc[s]), 32'd0);
      chk("reset_flags",   32'({dov[s], ddr[s]}), 32'd0);
      chk("reset_data",    dd[s], 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Deskew: staggered rows, one aligned column out.
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 4'(1 << i);
      in_data[i*8 +: 8] = 8'(10 + i);
      step();
    end
    in_val = '0;
    nv = 0; cap = '0;
    repeat (8) begin
      @(negedge clk);
      if (dv[0]) begin nv++; cap = dd[0]; end
    end
    chk("deskew_valid_cycles", 32'(nv), 32'd1);
    chk("deskew_column", cap, 32'h0D0C0B0A);
    step();

    // Arithmetic and saturation.
    out_rdy = 1'b0;
    set_row(0, 100, 50, 1);
    set_row(1, -100, 50, 2);
    set_row(2, 3, 5, 3);
    set_row(3, -7, 0, 0);
    in_val = 4'hF;
    step();
    in_val = '0;
    step(); step();
    chk("arith_sat_data",  dd[0], 32'hF902807F);
    chk("arith_wrap_data", dd[1], 32'hF9026A96);
    chk("arith_sat_ovf",   32'(dov[0]), 32'h3);
    chk("arith_wrap_ovf",  32'(dov[1]), 32'h3);
    out_rdy = 1'b1; step();
    out_rdy = 1'b0; flush = 1'b1; step();
    flush = 1'b0; step();
    chk("flush_clears_ovf", 32'(dov[0]), 32'd0);

    // Backpressure into full FIFOs.
    row_mode = '0; m_data = '0;
    for (int k = 1; k <= 5; k++) begin push_col(16 * k); step(); end
    in_val = '0;
    step(); step();
    chk("bp_row_cnt", 32'(dc[0]), 32'h924);
    chk("bp_drop",    32'(ddr[0]), 32'hF);
    chk("bp_head",    dd[0], 32'h13121110);
    out_rdy = 1'b1;
    repeat (6) step();
    chk("bp_drained", 32'(dc[0]), 32'd0);
    out_rdy = 1'b0; flush = 1'b1; step();
    flush = 1'b0; step();

    // Simultaneous push and pop on full rows.
    for (int k = 1; k <= 4; k++) begin push_col(16 * k); step(); end
    push_col(16 * 6); step();
    in_val = '0; out_rdy = 1'b1; step();
    out_rdy = 1'b0; step();
    chk("full_pushpop_cnt",  32'(dc[0]), 32'h924);
    chk("full_pushpop_drop", 32'(ddr[0]), 32'd0);
    chk("full_pushpop_head", dd[0], 32'h23222120);
    out_rdy = 1'b1;
    repeat (5) step();
    chk("full_pushpop_drained", 32'(dc[0]), 32'd0);

    // Wrap-around with toggling ready.
    xs = xfer;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) push_col(4 * (c / 2));
      else in_val = '0;
      out_rdy = (c % 2 == 1);
      step();
    end
    in_val = '0; out_rdy = 1'b1;
    repeat (6) step();
    chk("wrap_transfers", 32'(xfer - xs), 32'd20);
    chk("wrap_no_drop",   32'(ddr[0]), 32'd0);
    chk("wrap_empty",     32'(dc[0]), 32'd0);

    // Asynchronous reset with FIFOs half full.
    out_rdy = 1'b0;
    push_col(8'h50); step();
    push_col(8'h60); step();
    in_val = '0; step(); step();
    chk("pre_reset_cnt", 32'(dc[0]), 32'h492);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_val", 32'(dv[0]), 32'd0);
    chk("async_reset_cnt", 32'({dc[1], dc[0]}), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Flush together with an overflowing push.
    for (int i = 0; i < 4; i++) set_row(i, 100, 50, 1);
    in_val = 4'hF; flush = 1'b1;
    step();
    in_val = '0; flush = 1'b0;
    step(); step(); step();
    chk("flush_push_cnt",   32'(dc[0]), 32'd0);
    chk("flush_push_flags", 32'({dov[0], ddr[0]}), 32'd0);
    chk("flush_push_val",   32'(dv[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_drain.md
# rsa_drain

Parametrised output drain for the systolic PE array. It replaces the per-row sync adders with a registered per-row combine stage (pass, add, subtract, with saturation). Behind that stage sit per-row deskew FIFOs, so the staggered row results leave as one aligned X-wide column vector under a valid/ready handshake. It sits between the array's west-edge result outputs and the downstream matrix writeback.

## Interface
- X, 4, number of array rows (channels), ≥1
- RSA_DW, 32, signed data width
- DEPTH, 8, per-row FIFO depth, power of 2, ≥2
- SAT, 1, 1 = saturate on combine overflow; 0 = wrap
- clk  in  1  sole clock, rising edge
- sys_rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all FIFOs and flags
- in_val  in  X  per-row result strobe from the array
- in_data  in  X*RSA_DW  per-row result C; row i at [i*RSA_DW +: RSA_DW]
- M_data  in  X*RSA_DW  per-row addend M, sampled with in_val[i]
- row_mode  in  2*X  per-row mode; 00 C, 01 C+M, 10 C−M, 11 M−C
- out_val  out  1  aligned column vector available
- out_rdy  in  1  downstream accept
- out_data  out  X*RSA_DW  aligned column, row i at [i*RSA_DW +: RSA_DW]
- ovf_flag  out  X  sticky per row: a combine result saturated or wrapped
- drop_flag  out  X  sticky per row: a write was lost to a full FIFO
- row_cnt  out  X*($clog2(DEPTH)+1)  per-row FIFO occupancy

## Operation
- **Combine stage, per row:**
  - Registered.
  - Computed at RSA_DW+1 bits.
  - Overflow occurs when the result is outside [−2^(RSA_DW−1), 2^(RSA_DW−1)−1].
  - On overflow with SAT=1 the result clamps to the nearest bound; with SAT=0 it keeps the low RSA_DW bits.
  - Either way, overflow sets ovf_flag[i].
  - row_mode is sampled on the same edge as in_val[i].
- **FIFO, per row:** DEPTH entries, first-word-fall-through, fed by the combine register's valid.
- **Output:**
  - out_val = AND over all rows of (row FIFO non-empty).
  - out_data = concatenation of the FIFO heads.
  - A transfer occurs when out_val && out_rdy; it pops every row on the same edge.
- **Full FIFO:**
  - A push to a full row is dropped and sets drop_flag[i], unless a pop occurs on the same edge.
  - A simultaneous push and pop on a full row succeeds, and occupancy stays at DEPTH.
- **Empty FIFO:** a simultaneous push and pop on an empty row cannot happen, because out_val requires non-empty.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked separately.
- **flush:**
  - Empties all FIFOs, clears the combine valids, ovf_flag and drop_flag.
  - Takes priority over any push or pop in the same cycle.
  - A combine input on the flush cycle is discarded.
- **No control FSM.** Each row is an independent EMPTY / PARTIAL / FULL occupancy machine, with states decoded from row_cnt.

## Timing
- **Reset values:** all of the following are 0 while sys_rst = 0, asserted at any time, including mid-transfer:
  - out_val, out_data (heads of empty FIFOs read as 0), ovf_flag, drop_flag, row_cnt;
  - all pointers, combine registers and combine valids.
- **Latency:**
  - in_val[i] at edge t → combine register at t → FIFO write at t+1 → visible at head and counted in row_cnt after t+1.
  - out_val rises in the cycle after the last missing row is written; minimum input-to-out_val latency is 2 cycles.
- **Handshake:**
  - out_val never depends combinationally on out_rdy.
  - out_data is stable while out_val=1 && out_rdy=0.
- **Throughput:** one column per cycle when all rows are fed every cycle and out_rdy is held high.
- **Flags:** ovf_flag and drop_flag set on the edge after the triggering event. Once set, they clear only on flush or reset.

## Structure
- Shared package rsa_pkg holds:
  - mode encodings RSA_MODE_C / RSA_MODE_ADD / RSA_MODE_SUB / RSA_MODE_RSUB;
  - the saturation bound constants as functions of RSA_DW.
- Sub-module rsa_row_fifo (parameters RSA_DW, DEPTH): FWFT FIFO with push, pop, flush, full, empty and count. It is instantiated X times in a generate loop.
- The combine logic stays inline in rsa_drain.

## Test plan
- **Deskew.**
  - Stimulus: X=4, all modes 00; row i gets C=10+i at cycle i (staggered), out_rdy=1.
  - Response: out_val only in cycle 5; out_data = {13,12,11,10}, MSB row first; one transfer.
- **Arithmetic and saturation.**
  - Stimulus: RSA_DW=8, SAT=1; row 0 mode 01 with C=100, M=50; row 1 mode 10 with C=−100, M=50; row 2 mode 11 with C=3, M=5; row 3 mode 00 with C=−7.
  - Response: outputs 127, −128, 2, −7; ovf_flag=4'b0011.
  - Repeat with SAT=0: outputs −106 and 106.
- **Backpressure and full.**
  - Stimulus: DEPTH=4, out_rdy=0; 5 pushes to every row.
  - Response: row_cnt=4 each; drop_flag=4'hF; after out_rdy=1, exactly the first 4 columns drain in order.
- **Simultaneous push/pop on full.**
  - Stimulus: FIFOs full; one cycle with out_rdy=1 and all rows pushing.
  - Response: row_cnt stays 4; no drop_flag; the new column is emitted 4th.
- **Wrap-around.**
  - Stimulus: DEPTH=4; 20 columns streamed with out_rdy toggling 1/0.
  - Response: all 20 columns emerge in order; no drop.
- **Reset and flush mid-operation.**
  - Stimulus: assert sys_rst=0 asynchronously with FIFOs half full.
  - Response: out_val and row_cnt are 0 immediately.
  - Stimulus: after recovery, pulse flush together with a push.
  - Response: FIFOs remain empty; flags remain 0.
